// File: rtl/flag_pkg.sv
// Shared types for the flag stripe scheduler: colour triple, table entry and FSM state.
package flag_pkg;

    localparam int PKG_CORDW = 10;
    localparam int PKG_CHANW = 4;

    typedef struct packed {
        logic [PKG_CHANW-1:0] r;
        logic [PKG_CHANW-1:0] g;
        logic [PKG_CHANW-1:0] b;
    } rgb_t;

    // end_line is exclusive: the stripe covers lines below end_line
    typedef struct packed {
        logic [PKG_CORDW-1:0] end_line;
        rgb_t                 colour;
    } stripe_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/flag_stripe_ctrl_table.sv
// Stripe table: host-written shadow file, frame-swapped active file, two
// combinational read ports (end line for the advance test, colour for paint).
module stripe_table
    import flag_pkg::*;
#(
    parameter int STRIPES = 4,
    parameter int PW      = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [PW-1:0]        wr_idx,
    input  stripe_t              wr_data,
    input  logic                 swap,
    input  logic [PW-1:0]        end_idx,
    output logic [PKG_CORDW-1:0] end_val,
    input  logic [PW-1:0]        col_idx,
    output rgb_t                 col_val
);

    stripe_t shadow_r [STRIPES];
    stripe_t active_r [STRIPES];

    // Shadow write port and bulk shadow-to-active copy at the frame swap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STRIPES; i++) begin
                shadow_r[i] <= '0;
                active_r[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                shadow_r[wr_idx] <= wr_data;
            end
            if (swap) begin
                active_r <= shadow_r;
            end
        end
    end

    // End line of the current stripe, used to decide the next advance
    always_comb begin
        end_val = active_r[end_idx].end_line;
    end

    // Colour read bypasses to the shadow on a swap so the paint register
    // already loads the new table's colour in the swap cycle
    always_comb begin
        col_val = '0;
        if (swap) begin
            col_val = shadow_r[col_idx].colour;
        end else begin
            col_val = active_r[col_idx].colour;
        end
    end

endmodule

// File: rtl/flag_stripe_ctrl.sv
// Flag stripe scheduler top: config handshake, pending/error flags, FSM,
// line-by-line stripe pointer and the registered paint colour.
module flag_stripe_ctrl
    import flag_pkg::*;
#(
    parameter int CORDW   = PKG_CORDW,
    parameter int CHANW   = PKG_CHANW,
    parameter int STRIPES = 4
) (
    input  logic                     clk_pix,
    input  logic                     rst_pix_n,
    input  logic                     frame,
    input  logic                     line,
    input  logic [CORDW-1:0]         sy,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [$clog2(STRIPES):0] cfg_idx,
    input  logic [CORDW-1:0]         cfg_end,
    input  logic [3*CHANW-1:0]       cfg_colour,
    input  logic                     cfg_commit,
    input  logic [$clog2(STRIPES):0] cfg_count,
    output logic                     cfg_err,
    output logic                     running,
    output logic [CHANW-1:0]         paint_r,
    output logic [CHANW-1:0]         paint_g,
    output logic [CHANW-1:0]         paint_b
);

    localparam int IW = $clog2(STRIPES) + 1;
    localparam int PW = $clog2(STRIPES);
    localparam logic [IW-1:0] STRIPES_IW = IW'(STRIPES);
    localparam logic [IW-1:0] ONE_IW     = IW'(1);

    state_t        state_r, state_next_s;
    logic          pending_r, pending_next_s;
    logic          err_r, err_next_s;
    logic          ready_r;
    logic          running_r;
    logic [IW-1:0] shadow_count_r, shadow_count_next_s;
    logic [IW-1:0] active_count_r, active_count_next_s;
    logic [PW-1:0] ptr_r, ptr_next_s;
    rgb_t          colour_out_r, colour_next_s;

    logic            wr_en_s;
    logic            swap_s;
    stripe_t         wr_data_s;
    logic [PKG_CORDW-1:0] end_val_s;
    rgb_t            col_val_s;

    stripe_table #(
        .STRIPES (STRIPES),
        .PW      (PW)
    ) u_table (
        .clk     (clk_pix),
        .rst_n   (rst_pix_n),
        .wr_en   (wr_en_s),
        .wr_idx  (cfg_idx[PW-1:0]),
        .wr_data (wr_data_s),
        .swap    (swap_s),
        .end_idx (ptr_r),
        .end_val (end_val_s),
        .col_idx (ptr_next_s),
        .col_val (col_val_s)
    );

    // Pack the host write into a table entry
    always_comb begin
        wr_data_s = {cfg_end, cfg_colour};
    end

    // FSM next state, handshake decode, swap control and pointer sequencing
    always_comb begin
        state_next_s        = state_r;
        pending_next_s      = pending_r;
        err_next_s          = err_r;
        shadow_count_next_s = shadow_count_r;
        active_count_next_s = active_count_r;
        ptr_next_s          = ptr_r;
        wr_en_s             = 1'b0;
        swap_s              = 1'b0;

        // cfg_ready is low whenever a commit is pending, so a write never
        // coincides with a swap and the shadow is stable while it is copied
        if (cfg_valid && ready_r) begin
            if (cfg_idx < STRIPES_IW) begin
                wr_en_s = 1'b1;
            end else begin
                err_next_s = 1'b1;
            end
        end else begin
            wr_en_s = 1'b0;
        end

        if (cfg_commit && ready_r) begin
            if ((cfg_count != '0) && (cfg_count <= STRIPES_IW)) begin
                shadow_count_next_s = cfg_count;
                pending_next_s      = 1'b1;
            end else begin
                err_next_s = 1'b1;
            end
        end else begin
            shadow_count_next_s = shadow_count_r;
        end

        // A commit accepted with this frame leaves pending_r low here, so
        // it waits for the following frame
        if (frame) begin
            ptr_next_s = '0;
            if (pending_r) begin
                swap_s              = 1'b1;
                active_count_next_s = shadow_count_r;
                pending_next_s      = 1'b0;
                state_next_s        = RUN;
            end else begin
                swap_s = 1'b0;
            end
        end else if (line && (state_r == RUN)) begin
            if ((IW'(ptr_r) < (active_count_r - ONE_IW)) && (sy >= end_val_s)) begin
                ptr_next_s = ptr_r + 1'b1;
            end else begin
                ptr_next_s = ptr_r;
            end
        end else begin
            ptr_next_s = ptr_r;
        end
    end

    // Paint colour for the stripe selected by the next pointer; black in IDLE
    always_comb begin
        colour_next_s = '0;
        if (state_next_s == RUN) begin
            colour_next_s = col_val_s;
        end else begin
            colour_next_s = '0;
        end
    end

    // Control registers and registered outputs
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            state_r        <= IDLE;
            pending_r      <= 1'b0;
            err_r          <= 1'b0;
            ready_r        <= 1'b1;
            running_r      <= 1'b0;
            shadow_count_r <= '0;
            active_count_r <= '0;
            ptr_r          <= '0;
            colour_out_r   <= '0;
        end else begin
            state_r        <= state_next_s;
            pending_r      <= pending_next_s;
            err_r          <= err_next_s;
            ready_r        <= ~pending_next_s;
            running_r      <= (state_next_s == RUN);
            shadow_count_r <= shadow_count_next_s;
            active_count_r <= active_count_next_s;
            ptr_r          <= ptr_next_s;
            colour_out_r   <= colour_next_s;
        end
    end

    assign cfg_ready = ready_r;
    assign cfg_err   = err_r;
    assign running   = running_r;
    assign paint_r   = colour_out_r.r;
    assign paint_g   = colour_out_r.g;
    assign paint_b   = colour_out_r.b;

endmodule
